// File: rtl/rf_port_arb.sv
`default_nettype none
// =============================================================================
// Module  : rf_port_arb
// Purpose : Round-robin two-port arbiter in front of a single register file.
// Revision: 1.0
// =============================================================================
module rf_port_arb #(
  parameter int data_Width = 8,
  parameter int Addr_width = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  B_REQ,
  input  logic                  A_WR,
  input  logic                  B_WR,
  input  logic [Addr_width-1:0] A_ADDR,
  input  logic [Addr_width-1:0] B_ADDR,
  input  logic [data_Width-1:0] A_WDATA,
  input  logic [data_Width-1:0] B_WDATA,
  output logic                  A_GNT,
  output logic                  B_GNT,
  output logic [data_Width-1:0] A_RDATA,
  output logic [data_Width-1:0] B_RDATA,
  output logic                  A_RVLD,
  output logic                  B_RVLD,
  output logic                  A_ERR,
  output logic                  B_ERR,
  output logic [Addr_width-1:0] RF_Address,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [data_Width-1:0] RF_WrData,
  input  logic [data_Width-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_DONE    = 2'd2,
    S_WAIT_RD = 2'd3
  } state_t;

  localparam logic [7:0] c_rd_timeout = 8'(RD_TIMEOUT);

  state_t                r_state, w_state_nxt;
  logic                  r_owner_b, w_owner_b;
  logic                  r_wr, w_wr;
  logic                  r_last_b, w_last_b;
  logic [7:0]            r_cnt, w_cnt;
  logic                  r_a_gnt, w_a_gnt, r_b_gnt, w_b_gnt;
  logic                  r_a_rvld, w_a_rvld, r_b_rvld, w_b_rvld;
  logic                  r_a_err, w_a_err, r_b_err, w_b_err;
  logic [data_Width-1:0] r_a_rdata, w_a_rdata, r_b_rdata, w_b_rdata;
  logic [Addr_width-1:0] r_rf_addr, w_rf_addr;
  logic [data_Width-1:0] r_rf_wrdata, w_rf_wrdata;
  logic                  r_rf_wren, w_rf_wren, r_rf_rden, w_rf_rden;
  logic                  r_busy, w_busy;
  logic                  w_pick_b;
  logic                  w_ret;
  logic                  w_ret_err;
  logic [data_Width-1:0] w_ret_data;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_b   = r_owner_b;
    w_wr        = r_wr;
    w_last_b    = r_last_b;
    w_cnt       = r_cnt;
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_rf_wren   = 1'b0;
    w_rf_rden   = 1'b0;
    w_rf_addr   = r_rf_addr;
    w_rf_wrdata = r_rf_wrdata;
    w_pick_b    = B_REQ && (!A_REQ || !r_last_b);
    w_ret       = 1'b0;
    w_ret_err   = 1'b0;
    w_ret_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (A_REQ || B_REQ) begin
          w_owner_b   = w_pick_b;
          w_last_b    = w_pick_b;
          w_wr        = w_pick_b ? B_WR : A_WR;
          w_rf_addr   = w_pick_b ? B_ADDR : A_ADDR;
          w_rf_wrdata = w_pick_b ? B_WDATA : A_WDATA;
          w_a_gnt     = !w_pick_b;
          w_b_gnt     = w_pick_b;
          w_rf_wren   = w_wr;
          w_rf_rden   = !w_wr;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_cnt       = 8'd1;
        w_state_nxt = r_wr ? S_DONE : S_WAIT_RD;
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_WAIT_RD: begin
        // Valid takes priority over a timeout landing in the same cycle
        if (RF_RdData_Valid) begin
          w_ret       = 1'b1;
          w_ret_data  = RF_RdData;
          w_state_nxt = S_IDLE;
        end else if (r_cnt >= c_rd_timeout) begin
          w_ret       = 1'b1;
          w_ret_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_a_rvld  = w_ret && !r_owner_b;
    w_b_rvld  = w_ret && r_owner_b;
    w_a_err   = w_ret_err && !r_owner_b;
    w_b_err   = w_ret_err && r_owner_b;
    w_a_rdata = w_a_rvld ? w_ret_data : r_a_rdata;
    w_b_rdata = w_b_rvld ? w_ret_data : r_b_rdata;
    w_busy    = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_owner_b   <= 1'b0;
      r_wr        <= 1'b0;
      r_last_b    <= 1'b1;
      r_cnt       <= '0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvld    <= 1'b0;
      r_b_rvld    <= 1'b0;
      r_a_err     <= 1'b0;
      r_b_err     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_rf_addr   <= '0;
      r_rf_wrdata <= '0;
      r_rf_wren   <= 1'b0;
      r_rf_rden   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_b   <= w_owner_b;
      r_wr        <= w_wr;
      r_last_b    <= w_last_b;
      r_cnt       <= w_cnt;
      r_a_gnt     <= w_a_gnt;
      r_b_gnt     <= w_b_gnt;
      r_a_rvld    <= w_a_rvld;
      r_b_rvld    <= w_b_rvld;
      r_a_err     <= w_a_err;
      r_b_err     <= w_b_err;
      r_a_rdata   <= w_a_rdata;
      r_b_rdata   <= w_b_rdata;
      r_rf_addr   <= w_rf_addr;
      r_rf_wrdata <= w_rf_wrdata;
      r_rf_wren   <= w_rf_wren;
      r_rf_rden   <= w_rf_rden;
      r_busy      <= w_busy;
    end
  end

  assign A_GNT      = r_a_gnt;
  assign B_GNT      = r_b_gnt;
  assign A_RVLD     = r_a_rvld;
  assign B_RVLD     = r_b_rvld;
  assign A_ERR      = r_a_err;
  assign B_ERR      = r_b_err;
  assign A_RDATA    = r_a_rdata;
  assign B_RDATA    = r_b_rdata;
  assign RF_Address = r_rf_addr;
  assign RF_WrData  = r_rf_wrdata;
  assign RF_WrEn    = r_rf_wren;
  assign RF_RdEn    = r_rf_rden;
  assign BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_port_arb.sv
`default_nettype none
// =============================================================================
// Module  : tb_rf_port_arb
// Purpose : Directed and randomized self-checking bench for rf_port_arb.
// Revision: 1.0
// =============================================================================
module tb_rf_port_arb;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          A_REQ = 1'b0, B_REQ = 1'b0, A_WR = 1'b0, B_WR = 1'b0;
  logic [AW-1:0] A_ADDR = '0, B_ADDR = '0;
  logic [DW-1:0] A_WDATA = '0, B_WDATA = '0;
  logic          A_GNT, B_GNT, A_RVLD, B_RVLD, A_ERR, B_ERR;
  logic [DW-1:0] A_RDATA, B_RDATA;
  logic [AW-1:0] RF_Address;
  logic          RF_WrEn, RF_RdEn, BUSY;
  logic [DW-1:0] RF_WrData;
  logic [DW-1:0] RF_RdData = '0;
  logic          RF_RdData_Valid = 1'b0;

  rf_port_arb #(.data_Width(DW), .Addr_width(AW), .RD_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WR(A_WR), .B_WR(B_WR),
    .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .A_WDATA(A_WDATA), .B_WDATA(B_WDATA),
    .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
    .A_RVLD(A_RVLD), .B_RVLD(B_RVLD), .A_ERR(A_ERR), .B_ERR(B_ERR),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData),
    .RF_RdData_Valid(RF_RdData_Valid), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who was granted last, and what each requester last received
  bit            m_last_b;
  logic [DW-1:0] m_a_rdata, m_b_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {A_GNT, B_GNT, A_RVLD, B_RVLD, A_ERR, B_ERR, RF_WrEn, RF_RdEn, BUSY}, 0);
    chk({tag, "_addr"}, RF_Address, 0);
    chk({tag, "_wdat"}, RF_WrData, 0);
    chk({tag, "_rdat"}, {A_RDATA, B_RDATA}, 0);
  endtask

  task automatic model_reset();
    m_last_b  = 1'b1;
    m_a_rdata = '0;
    m_b_rdata = '0;
  endtask

  // vdel: WAIT_RD cycle (1-based) in which valid is presented; 0 = never
  task automatic do_op(input bit ar, input bit br, input bit aw, input bit bw,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                       input logic [DW-1:0] ad, input logic [DW-1:0] bd,
                       input int vdel, input logic [DW-1:0] rv);
    bit            pick_b, wr, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat, got;
    int            endk;
    pick_b   = br && (!ar || !m_last_b);
    m_last_b = pick_b;
    wr       = pick_b ? bw : aw;
    addr     = pick_b ? ba : aa;
    wdat     = pick_b ? bd : ad;
    A_REQ = ar; B_REQ = br; A_WR = aw; B_WR = bw;
    A_ADDR = aa; B_ADDR = ba; A_WDATA = ad; B_WDATA = bd;
    @(negedge CLK);
    chk("gnt", {A_GNT, B_GNT}, {!pick_b, pick_b});
    chk("strobes", {RF_WrEn, RF_RdEn}, {wr, !wr});
    chk("rf_addr", RF_Address, addr);
    chk("rf_wdata", RF_WrData, wdat);
    chk("busy_grant", BUSY, 1);
    A_REQ = 1'b0; B_REQ = 1'b0;
    if (wr) begin
      @(negedge CLK);
      chk("done_ctl", {A_GNT, B_GNT, RF_WrEn, RF_RdEn, BUSY}, 5'b00001);
      RF_RdData_Valid = 1'($urandom % 2);
      @(negedge CLK);
      RF_RdData_Valid = 1'b0;
      chk("post_wr_ctl", {BUSY, A_RVLD, B_RVLD}, 0);
      chk("rf_addr_hold", RF_Address, addr);
    end else begin
      err  = !(vdel >= 1 && vdel <= TO);
      endk = err ? TO : vdel;
      for (int k = 1; k <= endk; k++) begin
        @(negedge CLK);
        chk("wait_ctl", {A_RVLD, B_RVLD, RF_RdEn, BUSY}, 4'b0001);
        RF_RdData_Valid = (k == vdel);
        RF_RdData       = (k == vdel) ? rv : DW'($urandom);
      end
      @(negedge CLK);
      RF_RdData_Valid = 1'b0;
      got = err ? '0 : rv;
      if (pick_b) m_b_rdata = got; else m_a_rdata = got;
      chk("rvld", {A_RVLD, B_RVLD}, {!pick_b, pick_b});
      chk("err", {A_ERR, B_ERR}, {!pick_b && err, pick_b && err});
      chk("rdata", {A_RDATA, B_RDATA}, {m_a_rdata, m_b_rdata});
      chk("busy_ret", BUSY, 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // A write 0x5A to 0x3, BUSY spans GRANT and DONE
    do_op(1, 0, 1, 0, 4'h3, 4'h0, 8'h5A, 8'h00, 0, 8'h00);

    // Simultaneous requests after reset alternate A, B, A
    RST = 1'b0; @(negedge CLK); RST = 1'b1; model_reset(); @(negedge CLK);
    do_op(1, 1, 1, 1, 4'h1, 4'h9, 8'h11, 8'h99, 0, 8'h00);
    do_op(1, 1, 1, 1, 4'h2, 4'hA, 8'h22, 8'hAA, 0, 8'h00);
    do_op(1, 1, 1, 1, 4'h3, 4'hB, 8'h33, 8'hBB, 0, 8'h00);

    // B read of 0x2 answered 3 cycles after RdEn
    do_op(0, 1, 0, 0, 4'h0, 4'h2, 8'h00, 8'h00, 3, 8'hC3);
    // A read that times out; then valid exactly on the timeout cycle wins
    do_op(1, 0, 0, 0, 4'h7, 4'h0, 8'h00, 8'h00, 0, 8'h00);
    do_op(1, 0, 0, 0, 4'h8, 4'h0, 8'h00, 8'h00, TO, 8'h6E);

    // Spurious valid while idle
    RF_RdData_Valid = 1'b1; RF_RdData = 8'hEE;
    @(negedge CLK);
    RF_RdData_Valid = 1'b0;
    chk("idle_spur", {A_RVLD, B_RVLD, BUSY}, 0);
    @(negedge CLK);
    chk("idle_spur2", {A_RVLD, B_RVLD, BUSY}, 0);

    // Reset in the middle of a B read; late valid must be ignored
    B_REQ = 1'b1; B_WR = 1'b0; B_ADDR = 4'h5;
    @(negedge CLK);
    chk("mid_gnt", {A_GNT, B_GNT}, 2'b01);
    B_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge CLK);
    RST = 1'b1; RF_RdData_Valid = 1'b1; RF_RdData = 8'h77;
    @(negedge CLK);
    RF_RdData_Valid = 1'b0;
    chk("late_vld", {A_RVLD, B_RVLD, BUSY}, 0);
    @(negedge CLK);
    chk("late_vld2", {A_RVLD, B_RVLD, BUSY}, 0);
    model_reset();
    do_op(1, 1, 1, 1, 4'h4, 4'hC, 8'h44, 8'hCC, 0, 8'h00);

    // Randomized back-to-back traffic
    for (int n = 0; n < 60; n++) begin
      bit ar, br;
      ar = 1'($urandom % 2);
      br = 1'($urandom % 2);
      if (!ar && !br) ar = 1'b1;
      do_op(ar, br, 1'($urandom % 2), 1'($urandom % 2),
            AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
            int'($urandom_range(TO + 2, 0)), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/rf_port_arb.md
RF_PORT_ARB -- requirements
Module: rf_port_arb

Interface
REQ-001 SHALL have parameter data_Width, default 8, the register-file data width.
REQ-002 SHALL have parameter Addr_width, default 4, the register-file address width.
REQ-003 SHALL have parameter RD_TIMEOUT, default 8, the read-wait limit in cycles (legal range 2..255).
REQ-004 SHALL have port CLK, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports A_REQ / B_REQ, input, 1 each, access request from requester A (system controller) / B (auxiliary).
REQ-007 SHALL have ports A_WR / B_WR, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports A_ADDR / B_ADDR, input, Addr_width each, the target address.
REQ-009 SHALL have ports A_WDATA / B_WDATA, input, data_Width each, the write data.
REQ-010 SHALL have ports A_GNT / B_GNT, output, 1 each, a one-cycle accept pulse.
REQ-011 SHALL have ports A_RDATA / B_RDATA, output, data_Width each, the returned read data.
REQ-012 SHALL have ports A_RVLD / B_RVLD, output, 1 each, a one-cycle read-return pulse.
REQ-013 SHALL have ports A_ERR / B_ERR, output, 1 each, a one-cycle read-timeout pulse, coincident with RVLD.
REQ-014 SHALL have port RF_Address, output, Addr_width, the register-file address.
REQ-015 SHALL have ports RF_WrEn / RF_RdEn, output, 1 each, the register-file strobes.
REQ-016 SHALL have port RF_WrData, output, data_Width, the register-file write data.
REQ-017 SHALL have port RF_RdData, input, data_Width, the register-file read data.
REQ-018 SHALL have port RF_RdData_Valid, input, 1, the register-file read-data qualifier.
REQ-019 SHALL have port BUSY, output, 1: high whenever state is not IDLE.

Function
REQ-020 SHALL implement a four-state FSM with states IDLE, GRANT, DONE and WAIT_RD; every output SHALL be registered.
REQ-021 In IDLE, when any REQ is high at a clock edge, the block SHALL select a winner, latch its WR/ADDR/WDATA, and enter GRANT.
REQ-022 Arbitration SHALL be round-robin: a lone requester always wins; when both request, the one not granted last wins; the last-grant pointer SHALL update at each grant.
REQ-023 In GRANT (exactly 1 cycle), the block SHALL drive the winner's GNT=1, RF_Address/RF_WrData from the latched values, and RF_WrEn=WR or RF_RdEn=!WR.
REQ-024 After GRANT, a write SHALL go to DONE, and a read SHALL go to WAIT_RD.
REQ-025 DONE SHALL last 1 cycle, ignore all REQ, and then go to IDLE; write issue-to-issue spacing is therefore 3 cycles.
REQ-026 Requesters SHALL hold REQ and operands stable until GNT and deassert REQ in the cycle after GNT.
REQ-027 In WAIT_RD, the block SHALL ignore all REQ and count cycles from 1.
REQ-028 In WAIT_RD, on RF_RdData_Valid=1 the next cycle SHALL carry RDATA=RF_RdData (captured) and RVLD=1 for the owner, and the state SHALL return to IDLE.
REQ-029 In WAIT_RD, if RD_TIMEOUT cycles elapse without valid, the next cycle SHALL carry RVLD=1, ERR=1 and RDATA=0 for the owner, and the state SHALL return to IDLE.
REQ-030 If valid and timeout occur in the same cycle, valid SHALL win (ERR=0).
REQ-031 RF_RdData_Valid SHALL be ignored outside WAIT_RD.
REQ-032 RF_WrEn and RF_RdEn SHALL be high only in GRANT and never both high.
REQ-033 RF_Address and RF_WrData SHALL hold their last issued value between operations.
REQ-034 RDATA SHALL hold until the next return to the same requester; GNT, RVLD and ERR SHALL be single-cycle pulses.
REQ-035 The IDLE state in the cycle of an RVLD pulse SHALL sample REQ normally, so back-to-back operation is allowed.

Reset
REQ-036 RST=0 SHALL immediately force IDLE, clear all outputs and RDATA to 0, clear the counter, and set the last-grant pointer to B so A wins first.
REQ-037 A reset mid-read SHALL abandon the read; no RVLD SHALL follow, and a late RF_RdData_Valid SHALL be ignored.

Verification
REQ-038 Scenario: A write to addr 0x3 with data 0x5A -> A_GNT and RF_WrEn=1 one cycle later, RF_Address=0x3, RF_WrData=0x5A; BUSY=1 for 2 cycles.
REQ-039 Scenario: A_REQ and B_REQ both high after reset -> order A, B, A on repeated simultaneous requests.
REQ-040 Scenario: B read of addr 0x2, RF returns 0xC3 three cycles after RdEn -> B_RDATA=0xC3 and B_RVLD=1 one cycle after valid; A_RVLD=0.
REQ-041 Scenario: A read with no RF_RdData_Valid and RD_TIMEOUT=8 -> A_RVLD=1, A_ERR=1 and A_RDATA=0x00 after 8 cycles in WAIT_RD.
REQ-042 Scenario: RST asserted during WAIT_RD, then valid pulsed -> all outputs 0, no RVLD, and the next grant goes to A.
REQ-043 Scenario: a spurious RF_RdData_Valid during IDLE or DONE -> no RVLD and no state change.
